// File: rtl/peak_scheduler.sv
// peak_scheduler
// Tracks the largest-magnitude FFT bin inside two fixed bin windows (730 nm
// and 850 nm channels) for each frame and hands the result to a
// microcontroller with a valid/ready handshake. It also sequences the FFT
// reset and recovers from FFT overflow.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   fft_dat    in   FFT bin value, two's complement, DATLEN bits
//   fft_nd     in   fft_dat valid this cycle
//   fft_ovf    in   FFT overflow flag
//   fft_rst_n  out  active-low reset to the FFT (low while in FRST)
//   max730     out  peak magnitude in the 730 nm window
//   bin730     out  bin index of that peak
//   max850     out  peak magnitude in the 850 nm window
//   bin850     out  bin index of that peak
//   res_valid  out  result available
//   res_ready  in   result accepted by the microcontroller
//   ovf_err    out  sticky overflow flag
//   ovf_clr    in   clears ovf_err (an overflow in the same cycle wins)
module peak_scheduler #(
    parameter int DATLEN  = 12,
    parameter int NBINS   = 64,
    parameter int W730_LO = 10,
    parameter int W730_HI = 14,
    parameter int W850_LO = 20,
    parameter int W850_HI = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATLEN-1:0]         fft_dat,
    input  logic                      fft_nd,
    input  logic                      fft_ovf,
    output logic                      fft_rst_n,
    output logic [DATLEN-1:0]         max730,
    output logic [DATLEN-1:0]         max850,
    output logic [$clog2(NBINS)-1:0]  bin730,
    output logic [$clog2(NBINS)-1:0]  bin850,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      ovf_err,
    input  logic                      ovf_clr
);

    localparam int BW = $clog2(NBINS);
    localparam logic [DATLEN-1:0] MAG_MAX  = {1'b0, {(DATLEN-1){1'b1}}};
    localparam logic [DATLEN-1:0] MOST_NEG = {1'b1, {(DATLEN-1){1'b0}}};
    localparam bit EN730 = (W730_LO <= W730_HI);
    localparam bit EN850 = (W850_LO <= W850_HI);

    typedef enum logic [1:0] {FRST, COLLECT, PRESENT, SKIP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        frst_cnt;
    logic [BW-1:0]     bin_cnt;
    logic [31:0]       bin_ext;
    logic [DATLEN-1:0] mag;
    logic [DATLEN-1:0] run730;
    logic [DATLEN-1:0] run850;
    logic [BW-1:0]     rbin730;
    logic [BW-1:0]     rbin850;
    logic              skip_flag;
    logic              pend_flag;
    logic              last_bin;
    logic              handshake;
    logic              in730;
    logic              in850;
    logic              upd730;
    logic              upd850;

    // Magnitude of the incoming bin; the most negative code has no positive
    // counterpart, so it saturates to the largest positive value.
    always_comb begin
        if (!fft_dat[DATLEN-1]) begin
            mag = fft_dat;
        end else if (fft_dat == MOST_NEG) begin
            mag = MAG_MAX;
        end else begin
            mag = -fft_dat;
        end
    end

    // A window whose LO exceeds HI is disabled and never matches.
    assign bin_ext   = 32'(bin_cnt);
    assign in730     = EN730 && (bin_ext >= unsigned'(W730_LO)) && (bin_ext <= unsigned'(W730_HI));
    assign in850     = EN850 && (bin_ext >= unsigned'(W850_LO)) && (bin_ext <= unsigned'(W850_HI));
    assign last_bin  = (bin_cnt == BW'(NBINS - 1));
    assign handshake = (state == PRESENT) && res_ready;

    // Strictly-greater update keeps the first bin on ties.
    assign upd730 = (state == COLLECT) && fft_nd && in730 && (mag > run730);
    assign upd850 = (state == COLLECT) && fft_nd && in850 && (mag > run850);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FRST;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. The skip and pending flags are combined with the
    // current-cycle fft_nd/fft_ovf so events in the handshake cycle count.
    always_comb begin
        state_nxt = state;
        case (state)
            FRST: begin
                if (frst_cnt == 2'd3) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (fft_ovf)                 state_nxt = FRST;
                else if (fft_nd && last_bin) state_nxt = PRESENT;
            end
            PRESENT: begin
                if (res_ready) begin
                    if (pend_flag || fft_ovf)     state_nxt = FRST;
                    else if (skip_flag || fft_nd) state_nxt = SKIP;
                    else                          state_nxt = COLLECT;
                end
            end
            SKIP: begin
                if (fft_ovf)                 state_nxt = FRST;
                else if (fft_nd && last_bin) state_nxt = COLLECT;
            end
            default: state_nxt = FRST;
        endcase
    end

    // Output decode.
    always_comb begin
        fft_rst_n = (state != FRST);
        res_valid = (state == PRESENT);
    end

    // Datapath: FRST timer, bin counter, running maxima, presented result
    // and the PRESENT-only skip/pending flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frst_cnt  <= '0;
            bin_cnt   <= '0;
            run730    <= '0;
            run850    <= '0;
            rbin730   <= '0;
            rbin850   <= '0;
            max730    <= '0;
            max850    <= '0;
            bin730    <= '0;
            bin850    <= '0;
            skip_flag <= 1'b0;
            pend_flag <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            frst_cnt <= (state == FRST) ? frst_cnt + 2'd1 : 2'd0;

            if (state == FRST) begin
                bin_cnt <= '0;
            end else if (fft_nd) begin
                bin_cnt <= bin_cnt + 1'b1;
            end

            if ((state == FRST) || handshake) begin
                run730  <= '0;
                run850  <= '0;
                rbin730 <= '0;
                rbin850 <= '0;
            end else begin
                if (upd730) begin
                    run730  <= mag;
                    rbin730 <= bin_cnt;
                end
                if (upd850) begin
                    run850  <= mag;
                    rbin850 <= bin_cnt;
                end
            end

            // The last bin of the frame is folded in on the same edge.
            if ((state == COLLECT) && (state_nxt == PRESENT)) begin
                max730 <= upd730 ? mag     : run730;
                bin730 <= upd730 ? bin_cnt : rbin730;
                max850 <= upd850 ? mag     : run850;
                bin850 <= upd850 ? bin_cnt : rbin850;
            end

            skip_flag <= (state == PRESENT) && !handshake && (skip_flag || fft_nd);
            pend_flag <= (state == PRESENT) && !handshake && (pend_flag || fft_ovf);

            if (fft_ovf) begin
                ovf_err <= 1'b1;
            end else if (ovf_clr) begin
                ovf_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_peak_scheduler.sv
// tb_peak_scheduler
// Self-checking bench for peak_scheduler. Expected window peaks are computed
// from each driven frame and queued; a monitor pops and compares them on
// every handshake and checks that a presented result stays stable.
module tb_peak_scheduler;

    localparam int DATLEN  = 12;
    localparam int NBINS   = 64;
    localparam int W730_LO = 10;
    localparam int W730_HI = 14;
    localparam int W850_LO = 20;
    localparam int W850_HI = 24;

    typedef struct {
        int m730;
        int b730;
        int m850;
        int b850;
    } result_t;

    logic              clk;
    logic              reset;
    logic [DATLEN-1:0] fft_dat;
    logic              fft_nd;
    logic              fft_ovf;
    logic              fft_rst_n;
    logic [DATLEN-1:0] max730;
    logic [DATLEN-1:0] max850;
    logic [5:0]        bin730;
    logic [5:0]        bin850;
    logic              res_valid;
    logic              res_ready;
    logic              ovf_err;
    logic              ovf_clr;

    int checks = 0;
    int errors = 0;

    logic signed [DATLEN-1:0] frame [NBINS];
    result_t sb [$];

    result_t prev;
    logic    prev_valid = 1'b0;
    logic    prev_hs    = 1'b0;

    peak_scheduler #(
        .DATLEN (DATLEN),
        .NBINS  (NBINS),
        .W730_LO(W730_LO),
        .W730_HI(W730_HI),
        .W850_LO(W850_LO),
        .W850_HI(W850_HI)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .fft_dat  (fft_dat),
        .fft_nd   (fft_nd),
        .fft_ovf  (fft_ovf),
        .fft_rst_n(fft_rst_n),
        .max730   (max730),
        .max850   (max850),
        .bin730   (bin730),
        .bin850   (bin850),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .ovf_err  (ovf_err),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference peak search over one window of the current frame.
    function automatic void windowPeak(input int lo, input int hi, output int m, output int b);
        int v;
        m = 0;
        b = 0;
        for (int k = lo; k <= hi; k++) begin
            v = int'(frame[k]);
            if (v < 0) v = -v;
            if (v > 2047) v = 2047;
            if (v > m) begin
                m = v;
                b = k;
            end
        end
    endfunction

    function automatic result_t model();
        result_t r;
        windowPeak(W730_LO, W730_HI, r.m730, r.b730);
        windowPeak(W850_LO, W850_HI, r.m850, r.b850);
        return r;
    endfunction

    task automatic fillFrame(input int base);
        for (int k = 0; k < NBINS; k++) frame[k] = DATLEN'(base);
    endtask

    task automatic driveCycle(input logic [DATLEN-1:0] dat, input logic nd, input logic ovf);
        fft_dat = dat;
        fft_nd  = nd;
        fft_ovf = ovf;
        @(posedge clk);
        #1;
        fft_nd  = 1'b0;
        fft_ovf = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) driveCycle('0, 1'b0, 1'b0);
    endtask

    task automatic applyStimulus(input bit push);
        if (push) sb.push_back(model());
        for (int b = 0; b < NBINS; b++) driveCycle(frame[b], 1'b1, 1'b0);
    endtask

    // Scoreboard and hold monitor, sampled mid-cycle.
    always @(negedge clk) begin
        result_t e;
        if (reset) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_valid && !prev_hs) begin
                checkOutput("hold_valid", res_valid, 1);
                checkOutput("hold_max730", max730, prev.m730);
                checkOutput("hold_bin730", bin730, prev.b730);
                checkOutput("hold_max850", max850, prev.m850);
                checkOutput("hold_bin850", bin850, prev.b850);
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_max730", max730, e.m730);
                    checkOutput("sb_bin730", bin730, e.b730);
                    checkOutput("sb_max850", max850, e.m850);
                    checkOutput("sb_bin850", bin850, e.b850);
                end
            end
            prev_valid = res_valid;
            prev_hs    = res_valid && res_ready;
            prev.m730  = max730;
            prev.b730  = bin730;
            prev.m850  = max850;
            prev.b850  = bin850;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b1;
        fft_dat   = '0;
        fft_nd    = 1'b0;
        fft_ovf   = 1'b0;
        res_ready = 1'b1;
        ovf_clr   = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_fft_rst_n", fft_rst_n, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_max730", max730, 0);
        checkOutput("rst_bin850", bin850, 0);
        checkOutput("rst_ovf_err", ovf_err, 0);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("frst_cycle%0d", c), fft_rst_n, (c >= 4) ? 1 : 0);
            checkOutput("frst_res_valid", res_valid, 0);
            idle(1);
        end

        // Basic frame, one-cycle latency.
        $display("[TB] basic frame");
        fillFrame(5);
        frame[12] = 12'sd300;
        frame[13] = -12'sd500;
        frame[22] = 12'h800;
        applyStimulus(1);
        checkOutput("lat_res_valid", res_valid, 1);
        checkOutput("basic_max730", max730, 500);
        checkOutput("basic_bin730", bin730, 13);
        checkOutput("basic_max850", max850, 2047);
        checkOutput("basic_bin850", bin850, 22);
        idle(1);
        checkOutput("pulse_res_valid", res_valid, 0);
        checkOutput("after_max730", max730, 500);
        idle(1);

        // Ties keep the first bin.
        $display("[TB] ties");
        fillFrame(5);
        frame[10] = 12'sd100;
        frame[11] = -12'sd100;
        frame[14] = 12'sd100;
        frame[21] = 12'sd7;
        applyStimulus(1);
        checkOutput("tie_bin730", bin730, 10);
        checkOutput("tie_max730", max730, 100);
        idle(2);

        // Backpressure with a frame streaming underneath.
        $display("[TB] backpressure and skip");
        res_ready = 1'b0;
        for (int k = 0; k < NBINS; k++) frame[k] = DATLEN'(k * 3 - 90);
        applyStimulus(1);
        fillFrame(900);
        for (int i = 0; i < 2 * NBINS; i++) begin
            if (i == 70) res_ready = 1'b1;
            driveCycle(frame[i / 2], (i % 2) == 0, 1'b0);
        end
        for (int k = 0; k < NBINS; k++) frame[k] = DATLEN'($urandom);
        applyStimulus(1);
        checkOutput("third_res_valid", res_valid, 1);
        idle(2);
        checkOutput("sb_drained_skip", sb.size(), 0);

        // Reset while a result is waiting.
        $display("[TB] reset mid-present");
        res_ready = 1'b0;
        fillFrame(-33);
        applyStimulus(1);
        idle(3);
        sb.delete();
        reset = 1'b1;
        idle(1);
        checkOutput("midrst_res_valid", res_valid, 0);
        checkOutput("midrst_max850", max850, 0);
        checkOutput("midrst_bin730", bin730, 0);
        reset = 1'b0;
        res_ready = 1'b1;
        idle(4);
        checkOutput("midrst_fft_rst_n", fft_rst_n, 1);

        // Overflow during COLLECT.
        $display("[TB] overflow in collect");
        fillFrame(400);
        for (int b = 0; b <= 30; b++) driveCycle(frame[b], 1'b1, b == 30);
        checkOutput("ovf_err_set", ovf_err, 1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("ovf_frst%0d", k), fft_rst_n, 0);
            idle(1);
        end
        checkOutput("ovf_frst_done", fft_rst_n, 1);
        checkOutput("ovf_no_result", res_valid, 0);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        checkOutput("ovf_err_clr", ovf_err, 0);
        for (int k = 0; k < NBINS; k++) frame[k] = DATLEN'($urandom);
        applyStimulus(1);
        idle(2);

        // Overflow and clear together: set wins.
        ovf_clr = 1'b1;
        driveCycle('0, 1'b0, 1'b1);
        ovf_clr = 1'b0;
        checkOutput("ovf_set_wins", ovf_err, 1);
        idle(4);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;

        // Overflow while presenting.
        $display("[TB] overflow in present");
        res_ready = 1'b0;
        fillFrame(1);
        frame[23] = -12'sd1234;
        frame[12] = 12'sd77;
        applyStimulus(1);
        driveCycle('0, 1'b0, 1'b1);
        checkOutput("povf_err", ovf_err, 1);
        checkOutput("povf_res_valid", res_valid, 1);
        res_ready = 1'b1;
        idle(1);
        checkOutput("povf_done_valid", res_valid, 0);
        checkOutput("povf_frst", fft_rst_n, 0);
        idle(4);
        checkOutput("povf_frst_done", fft_rst_n, 1);

        checkOutput("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peak_scheduler.md
PEAK_SCHEDULER -- requirements
Module: peak_scheduler

Interface
REQ-001 The block SHALL take one parameter per line: DATLEN, 12, width of the FFT output word.
REQ-002 Parameter: NBINS, 64, FFT bins per frame (power of two).
REQ-003 Parameters: W730_LO, 10, and W730_HI, 14, the inclusive bin window for the 730 nm channel.
REQ-004 Parameters: W850_LO, 20, and W850_HI, 24, the inclusive bin window for the 850 nm channel.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset; ports are listed one per line below.
REQ-006 clk  in  1  the single clock; all logic is rising-edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 fft_dat  in  DATLEN  FFT output bin, two's complement.
REQ-009 fft_nd  in  1  fft_dat is valid this cycle.
REQ-010 fft_ovf  in  1  FFT overflow flag.
REQ-011 fft_rst_n  out  1  active-low reset driven to the FFT.
REQ-012 max730, max850  out  DATLEN each  window peak magnitudes.
REQ-013 bin730, bin850  out  log2(NBINS) each  bin index of each peak.
REQ-014 res_valid  out  1  result available to the microcontroller.
REQ-015 res_ready  in  1  microcontroller accepts the result.
REQ-016 ovf_err  out  1  sticky overflow flag.
REQ-017 ovf_clr  in  1  clears ovf_err.

Function
REQ-018 The FSM SHALL have four states: FRST, COLLECT, PRESENT and SKIP.
REQ-019 FRST SHALL drive fft_rst_n=0 for exactly 4 cycles, clear the bin counter and the running maxima, and then go to COLLECT; fft_rst_n=1 in all other states.
REQ-020 The bin counter SHALL increment (modulo NBINS) on every fft_nd in COLLECT, PRESENT and SKIP, and SHALL ignore fft_nd in FRST.
REQ-021 Magnitude SHALL be |fft_dat|, with the most negative value saturated to 2^(DATLEN-1)-1.
REQ-022 In COLLECT, when fft_nd=1 and the bin is inside a window, that window's running max SHALL be updated only if the magnitude is strictly greater; the bin index is stored with it, so the first occurrence wins ties.
REQ-023 A window with LO>HI SHALL never match; its result is 0, bin 0.
REQ-024 The running maxima SHALL start each frame at 0 with bin 0.
REQ-025 On an accepted bin NBINS-1 in COLLECT, the FSM SHALL go to PRESENT; max*/bin* SHALL load the final maxima, including that last bin, and res_valid SHALL be 1 on the next cycle, giving 1-cycle latency.
REQ-026 In PRESENT, res_valid and max*/bin* SHALL be held stable until res_valid&&res_ready; res_valid SHALL never drop without a handshake.
REQ-027 Any fft_nd in PRESENT, including in the handshake cycle, SHALL set a skip flag.
REQ-028 On handshake, the FSM SHALL go to SKIP if the skip flag is set, else to COLLECT; the skip flag and running maxima are cleared on that transition, and res_valid goes to 0.
REQ-029 SKIP SHALL discard bins and return to COLLECT after bin NBINS-1 is accepted.
REQ-030 Outputs max*/bin* SHALL keep their last presented values outside PRESENT.
REQ-031 fft_ovf=1 SHALL set ovf_err; if fft_ovf and ovf_clr are asserted in the same cycle, set wins.
REQ-032 fft_ovf in COLLECT or SKIP SHALL go to FRST next cycle, discarding the partial frame.
REQ-033 fft_ovf in PRESENT SHALL latch a pending flag; the handshake still completes, and the FSM then goes to FRST instead of COLLECT/SKIP.

Reset
REQ-034 While reset=1: state=FRST with its 4-cycle count restarted, fft_rst_n=0, res_valid=0, max730=max850=0, bin730=bin850=0, ovf_err=0, and the skip and pending flags cleared.
REQ-035 Reset asserted mid-frame or mid-handshake SHALL abandon the frame; a pending result is lost.

Verification
REQ-036 Reset, then idle for 6 cycles -> fft_rst_n is 0 for cycles 0-3 after release, 1 from cycle 4; res_valid=0.
REQ-037 One frame, bin12=+300, bin13=-500, bin22=-2048, others 5, res_ready=1 -> res_valid is pulsed 1 cycle after bin63 with max730=500/bin730=13 and max850=2047/bin850=22.
REQ-038 Ties: bins 10 and 14 both =100 -> bin730=10.
REQ-039 Hold res_ready=0 for 70 cycles while the next frame streams, then assert res_ready -> outputs stable throughout; that frame is skipped; the third frame's result is presented.
REQ-040 fft_ovf pulsed at bin 30 of COLLECT -> ovf_err=1, fft_rst_n is low for 4 cycles, and no result for that frame; ovf_clr then clears ovf_err.
REQ-041 fft_ovf in PRESENT -> the result is still delivered on handshake, then FRST follows.
